// File: rtl/riscv_top_core.sv
// Single-cycle RV32I-subset core: control unit, datapath, register file, memories.

package riscv_top_core_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_t;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_IMM} res_sel_t;
endpackage

// Instruction memory: word-indexed, read-only from the core's point of view.
module riscv_imem #(
  parameter int unsigned WORDS = 256
) (
  input  logic [$clog2(WORDS)-1:0] a,
  output logic [31:0]              rd
);
  logic [31:0] mem [0:WORDS-1];

  assign rd = mem[a];
endmodule

// Register file: two combinational reads, one synchronous write, x0 hard-wired to 0.
module riscv_rf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we3,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  input  logic [31:0] wd3,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  // Clear all registers on reset; ignore writes addressed to x0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we3 && a3 != 5'd0) begin
      regs[a3] <= wd3;
    end
  end

  assign rd1 = (a1 == 5'd0) ? '0 : regs[a1];
  assign rd2 = (a2 == 5'd0) ? '0 : regs[a2];
endmodule

// Control unit: decodes opcode/funct fields into datapath controls.
module riscv_cu
  import riscv_top_core_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       eq,
  input  logic       lt,
  input  logic       ltu,
  output logic       RegWrite,
  output logic       mem_write,
  output logic       alu_src,
  output logic       pc_src,
  output res_sel_t   res_sel,
  output imm_sel_t   imm_sel,
  output alu_op_t    alu_op
);
  logic    take;
  alu_op_t arith_op;

  // Branch condition selected by funct3; undefined encodings never branch.
  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000:  take = eq;
      3'b001:  take = !eq;
      3'b100:  take = lt;
      3'b101:  take = !lt;
      3'b110:  take = ltu;
      3'b111:  take = !ltu;
      default: take = 1'b0;
    endcase
  end

  // ALU operation for R-type and I-ALU; SUB only exists in the register form.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (funct7b5 && op[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // Main decoder; unknown opcodes fall through the defaults as a NOP.
  always_comb begin
    RegWrite  = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    pc_src    = 1'b0;
    res_sel   = RES_ALU;
    imm_sel   = IMM_I;
    alu_op    = ALU_ADD;
    case (op)
      7'b0110011: begin RegWrite = 1'b1; alu_op = arith_op; end
      7'b0010011: begin RegWrite = 1'b1; alu_src = 1'b1; alu_op = arith_op; end
      7'b0000011: begin RegWrite = 1'b1; alu_src = 1'b1; res_sel = RES_MEM; end
      7'b0100011: begin mem_write = 1'b1; alu_src = 1'b1; imm_sel = IMM_S; end
      7'b1100011: begin imm_sel = IMM_B; pc_src = take; end
      7'b1101111: begin RegWrite = 1'b1; imm_sel = IMM_J; res_sel = RES_PC4; pc_src = 1'b1; end
      7'b0110111: begin RegWrite = 1'b1; imm_sel = IMM_U; res_sel = RES_IMM; end
      default: ;
    endcase
  end
endmodule

// Datapath: PC, fetch, register file, immediate generation, ALU, data memory, write-back.
module riscv_dp
  import riscv_top_core_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reg_write,
  input  logic       mem_write,
  input  logic       alu_src,
  input  logic       pc_src,
  input  res_sel_t   res_sel,
  input  imm_sel_t   imm_sel,
  input  alu_op_t    alu_op,
  output logic [6:0] op,
  output logic [2:0] funct3,
  output logic       funct7b5,
  output logic       eq,
  output logic       lt,
  output logic       ltu
);
  localparam int unsigned IW = $clog2(IMEM_WORDS);
  localparam int unsigned DW = $clog2(DMEM_WORDS);

  logic [31:0] pc, pc_plus4, pc_target, instr, imm_ext;
  logic [31:0] src_a, rd2, src_b, alu_result, read_data, result;
  logic [31:0] dmem [0:DMEM_WORDS-1];

  riscv_imem #(.WORDS(IMEM_WORDS)) mem_inst (.a(pc[IW+1:2]), .rd(instr));

  riscv_rf rf (
    .clk(clk), .reset(reset), .we3(reg_write),
    .a1(instr[19:15]), .a2(instr[24:20]), .a3(instr[11:7]),
    .wd3(result), .rd1(src_a), .rd2(rd2)
  );

  assign op        = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7b5  = instr[30];
  assign eq        = (src_a == rd2);
  assign lt        = ($signed(src_a) < $signed(rd2));
  assign ltu       = (src_a < rd2);
  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_ext;
  assign src_b     = alu_src ? imm_ext : rd2;
  assign read_data = dmem[alu_result[DW+1:2]];

  // PC register; asynchronous reset returns fetch to address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_src ? pc_target : pc_plus4;
  end

  // Data memory write; gated by reset so nothing commits while held in reset.
  always_ff @(posedge clk) begin
    if (reset && mem_write) dmem[alu_result[DW+1:2]] <= rd2;
  end

  // Sign-extended immediate for each instruction format.
  always_comb begin
    imm_ext = '0;
    case (imm_sel)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm_ext = {instr[31:12], 12'b0};
      default: imm_ext = '0;
    endcase
  end

  // ALU; shift amount is the low five bits of the second operand.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_SLL:  alu_result = src_a << src_b[4:0];
      ALU_SLT:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {31'b0, src_a < src_b};
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SRL:  alu_result = src_a >> src_b[4:0];
      ALU_SRA:  alu_result = 32'($signed(src_a) >>> src_b[4:0]);
      ALU_OR:   alu_result = src_a | src_b;
      ALU_AND:  alu_result = src_a & src_b;
      default:  alu_result = '0;
    endcase
  end

  // Write-back source select.
  always_comb begin
    result = alu_result;
    case (res_sel)
      RES_ALU: result = alu_result;
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      RES_IMM: result = imm_ext;
      default: result = alu_result;
    endcase
  end
endmodule

// Top level: control unit and datapath.
module riscv_top_core
  import riscv_top_core_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  logic       reg_write, mem_write, alu_src, pc_src, funct7b5, eq, lt, ltu;
  logic [6:0] op;
  logic [2:0] funct3;
  res_sel_t   res_sel;
  imm_sel_t   imm_sel;
  alu_op_t    alu_op;

  riscv_cu cu (
    .op(op), .funct3(funct3), .funct7b5(funct7b5), .eq(eq), .lt(lt), .ltu(ltu),
    .RegWrite(reg_write), .mem_write(mem_write), .alu_src(alu_src), .pc_src(pc_src),
    .res_sel(res_sel), .imm_sel(imm_sel), .alu_op(alu_op)
  );

  riscv_dp #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dp (
    .clk(clk), .reset(reset), .reg_write(reg_write), .mem_write(mem_write),
    .alu_src(alu_src), .pc_src(pc_src), .res_sel(res_sel), .imm_sel(imm_sel),
    .alu_op(alu_op), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .eq(eq), .lt(lt), .ltu(ltu)
  );
endmodule

// File: tb/tb_riscv_top_core.sv
// Directed-program bench for riscv_top_core; observes register-file writes.
module tb_riscv_top_core;
  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  riscv_top_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (.clk(clk), .reset(reset));

  logic [4:0]  log_rd [$];
  logic [31:0] log_wd [$];

  // Expected nonzero-rd write sequence of the program, in retirement order.
  logic [4:0] exp_rd [19] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                              5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd1, 5'd18};
  logic [31:0] exp_wd [19] = '{32'd15, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 32'd1,
                               32'd20, 32'd10, 32'd10, 32'd15, 32'd5, 32'd480, 32'd0,
                               32'hFFFF_FFFF, 32'h0000_00AA, 32'd20, 32'd148, 32'h1234_5000};

  // Record every register write that will commit on the next rising edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && dut.cu.RegWrite === 1'b1 && dut.dp.rf.a3 !== 5'd0) begin
      log_rd.push_back(dut.dp.rf.a3);
      log_wd.push_back(dut.dp.rf.wd3);
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic load_program();
    logic [2:0] bf3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [4:0] t1 [6]  = '{5'd1, 5'd1, 5'd3, 5'd1, 5'd1, 5'd3};
    logic [4:0] t2 [6]  = '{5'd1, 5'd2, 5'd1, 5'd3, 5'd3, 5'd1};
    logic [4:0] n1 [6]  = '{5'd1, 5'd1, 5'd1, 5'd3, 5'd3, 5'd1};
    logic [4:0] n2 [6]  = '{5'd2, 5'd1, 5'd3, 5'd1, 5'd1, 5'd3};
    for (int i = 0; i < 256; i++) dut.dp.mem_inst.mem[i] = 32'h0000_0013;
    dut.dp.mem_inst.mem[0]  = enc_i(12'd15,  5'd0, 3'b000, 5'd1, 7'b0010011);
    dut.dp.mem_inst.mem[1]  = enc_i(12'd5,   5'd0, 3'b000, 5'd2, 7'b0010011);
    dut.dp.mem_inst.mem[2]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd3, 7'b0010011);
    dut.dp.mem_inst.mem[3]  = enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd4);
    dut.dp.mem_inst.mem[4]  = enc_r(7'h00, 5'd1, 5'd3, 3'b011, 5'd5);
    dut.dp.mem_inst.mem[5]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd6);
    dut.dp.mem_inst.mem[6]  = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd7);
    dut.dp.mem_inst.mem[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd8);
    dut.dp.mem_inst.mem[8]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd9);
    dut.dp.mem_inst.mem[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10);
    dut.dp.mem_inst.mem[10] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd11);
    dut.dp.mem_inst.mem[11] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd12);
    dut.dp.mem_inst.mem[12] = enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd13);
    dut.dp.mem_inst.mem[13] = enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd14);
    dut.dp.mem_inst.mem[14] = enc_r(7'h20, 5'd1, 5'd3, 3'b101, 5'd15);
    for (int b = 0; b < 6; b++) begin
      int base = 15 + 3 * b;
      dut.dp.mem_inst.mem[base]     = enc_b(13'd8, t2[b], t1[b], bf3[b]);
      dut.dp.mem_inst.mem[base + 1] = enc_i(12'd1, 5'd0, 3'b000, 5'd30, 7'b0010011);
      dut.dp.mem_inst.mem[base + 2] = enc_b(13'((100 - (base + 2)) * 4), n2[b], n1[b], bf3[b]);
    end
    dut.dp.mem_inst.mem[33]  = enc_i(12'h0AA, 5'd0, 3'b000, 5'd16, 7'b0010011);
    dut.dp.mem_inst.mem[34]  = enc_s(12'd4, 5'd8, 5'd0);
    dut.dp.mem_inst.mem[35]  = enc_i(12'd4, 5'd0, 3'b010, 5'd17, 7'b0000011);
    dut.dp.mem_inst.mem[36]  = enc_j(21'd8, 5'd1);
    dut.dp.mem_inst.mem[37]  = enc_i(12'd3, 5'd0, 3'b000, 5'd30, 7'b0010011);
    dut.dp.mem_inst.mem[38]  = {20'h12345, 5'd18, 7'b0110111};
    dut.dp.mem_inst.mem[39]  = enc_b(13'd0, 5'd0, 5'd0, 3'b000);
    dut.dp.mem_inst.mem[100] = enc_i(12'd2, 5'd0, 3'b000, 5'd30, 7'b0010011);
    dut.dp.mem_inst.mem[101] = enc_b(13'd0, 5'd0, 5'd0, 3'b000);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut.dp.pc !== 32'd0) $display("FAIL reset_pc: got %h expected 00000000", dut.dp.pc);
    else passed++;
    for (int r = 0; r < 32; r++) begin
      total++;
      if (dut.dp.rf.regs[r] !== 32'd0)
        $display("FAIL reset_reg x%0d: got %h expected 00000000", r, dut.dp.rf.regs[r]);
      else passed++;
    end
  endtask

  task automatic test_run();
    bit halted = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 500 && !halted; c++) begin
      @(negedge clk);
      if (dut.dp.pc === 32'd156) halted = 1'b1;
    end
    repeat (3) @(negedge clk);
    total++;
    if (!halted) $display("FAIL run_halt: pc %h never reached 0000009c within 500 cycles", dut.dp.pc);
    else passed++;
    total++;
    if (dut.dp.pc !== 32'd156) $display("FAIL self_loop_pc: got %h expected 0000009c", dut.dp.pc);
    else passed++;
  endtask

  task automatic test_init();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= log_rd.size() || log_rd[i] !== exp_rd[i] || log_wd[i] !== exp_wd[i])
        $display("FAIL init[%0d]: got x%0d=%h expected x%0d=%h", i, log_rd[i], log_wd[i], exp_rd[i], exp_wd[i]);
      else passed++;
    end
  endtask

  task automatic test_compare();
    for (int i = 3; i < 7; i++) begin
      total++;
      if (i >= log_rd.size() || log_rd[i] !== exp_rd[i] || log_wd[i] !== exp_wd[i])
        $display("FAIL compare[%0d]: got x%0d=%h expected x%0d=%h", i, log_rd[i], log_wd[i], exp_rd[i], exp_wd[i]);
      else passed++;
    end
  endtask

  task automatic test_alu();
    for (int i = 7; i < 12; i++) begin
      total++;
      if (i >= log_rd.size() || log_rd[i] !== exp_rd[i] || log_wd[i] !== exp_wd[i])
        $display("FAIL alu[%0d]: got x%0d=%h expected x%0d=%h", i, log_rd[i], log_wd[i], exp_rd[i], exp_wd[i]);
      else passed++;
    end
  endtask

  task automatic test_shifts();
    for (int i = 12; i < 15; i++) begin
      total++;
      if (i >= log_rd.size() || log_rd[i] !== exp_rd[i] || log_wd[i] !== exp_wd[i])
        $display("FAIL shift[%0d]: got x%0d=%h expected x%0d=%h", i, log_rd[i], log_wd[i], exp_rd[i], exp_wd[i]);
      else passed++;
    end
  endtask

  task automatic test_branches();
    int x30_writes = 0;
    int pos16 = -1;
    foreach (log_rd[i]) begin
      if (log_rd[i] == 5'd30) x30_writes++;
      if (log_rd[i] == 5'd16 && pos16 < 0) pos16 = i;
    end
    total++;
    if (x30_writes != 0) $display("FAIL branch_trap: got %0d x30 writes expected 0", x30_writes);
    else passed++;
    total++;
    if (pos16 != 15) $display("FAIL branch_count: x16 write is number %0d expected 16", pos16 + 1);
    else passed++;
    total++;
    if (log_wd.size() < 16 || log_wd[15] !== 32'h0000_00AA)
      $display("FAIL branch_x16: got %h expected 000000aa", log_wd[15]);
    else passed++;
    total++;
    if (dut.dp.rf.regs[30] !== 32'd0) $display("FAIL branch_x30: got %h expected 00000000", dut.dp.rf.regs[30]);
    else passed++;
  endtask

  task automatic test_mem_jump();
    for (int i = 16; i < 19; i++) begin
      total++;
      if (i >= log_rd.size() || log_rd[i] !== exp_rd[i] || log_wd[i] !== exp_wd[i])
        $display("FAIL memjump[%0d]: got x%0d=%h expected x%0d=%h", i, log_rd[i], log_wd[i], exp_rd[i], exp_wd[i]);
      else passed++;
    end
    total++;
    if (log_rd.size() != 19) $display("FAIL write_total: got %0d expected 19", log_rd.size());
    else passed++;
    total++;
    if (dut.dp.rf.regs[17] !== 32'd20) $display("FAIL lw_reg: got %h expected 00000014", dut.dp.rf.regs[17]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    @(posedge clk);
    #1;
    log_rd.delete();
    log_wd.delete();
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (dut.dp.rf.regs[1] !== 32'd15) $display("FAIL midrun_x1: got %h expected 0000000f", dut.dp.rf.regs[1]);
    else passed++;
    #2 reset = 1'b0;
    #1;
    total++;
    if (dut.dp.pc !== 32'd0) $display("FAIL midreset_pc: got %h expected 00000000", dut.dp.pc);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) begin
      total++;
      if (dut.dp.rf.regs[r] !== 32'd0)
        $display("FAIL midreset_reg x%0d: got %h expected 00000000", r, dut.dp.rf.regs[r]);
      else passed++;
    end
    total++;
    if (dut.dp.pc !== 32'd0) $display("FAIL held_reset_pc: got %h expected 00000000", dut.dp.pc);
    else passed++;
  endtask

  initial begin
    reset = 1'b0;
    load_program();
    test_reset();
    test_run();
    test_init();
    test_compare();
    test_alu();
    test_shifts();
    test_branches();
    test_mem_jump();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
